alu_mem_sequencer: RTL and testbench

//  Hardware initiator for the memory/ALU datapath. It accepts one command, reads

---
 rtl/alu_mem_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_mem_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: fetches operands A and B from memory, drives the ALU,
// registers result/carry and optionally writes the result back.
// Ports: clk/reset (async, active-low); start + a_addr/b_addr/dst_addr/
//   opcode/wb command; busy/done status; result/carry registered ALU
//   outputs; mem_we/mem_re/mem_addr/mem_wdata/mem_rdata memory port;
//   alu_a/alu_b/alu_op registered ALU operands, alu_result/alu_carry back.
module alu_mem_sequencer #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int OP_W       = 4,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [OP_W-1:0]   opcode,
  input  logic              wb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry
);

  localparam int CNT_W =
    (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    WAIT_A,
    RD_B,
    WAIT_B,
    EXEC,
    WR,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] b_q;
  logic [ADDR_W-1:0] dst_q;
  logic              wb_q;
  logic              last;

  assign last = (cnt == CNT_LAST);

  // Strobes are registered, so they are raised on the edge that
  // enters RD_A/RD_B/WR and dropped by the default on the next edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      b_q       <= '0;
      dst_q     <= '0;
      wb_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            b_q      <= b_addr;
            dst_q    <= dst_addr;
            wb_q     <= wb;
            alu_op   <= opcode;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= a_addr;
            state    <= RD_A;
          end
        end
        RD_A: begin
          cnt   <= '0;
          state <= WAIT_A;
        end
        WAIT_A: begin
          if (last) begin
            alu_a    <= mem_rdata;
            mem_re   <= 1'b1;
            mem_addr <= b_q;
            state    <= RD_B;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_B: begin
          cnt   <= '0;
          state <= WAIT_B;
        end
        WAIT_B: begin
          if (last) begin
            alu_b <= mem_rdata;
            state <= EXEC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          result <= alu_result;
          carry  <= alu_carry;
          if (wb_q) begin
            mem_we    <= 1'b1;
            mem_addr  <= dst_q;
            mem_wdata <= alu_result;
            state     <= WR;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        WR: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// tb_alu_mem_sequencer: two sequencers (read latency 1 and 2) with their own
// memory and ALU, checked every cycle against a command-schedule model.
module tb_alu_mem_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start [2];
  logic [11:0] a_addr [2];
  logic [11:0] b_addr [2];
  logic [11:0] dst_addr [2];
  logic [3:0]  opcode [2];
  logic        wb [2];
  logic        busy [2];
  logic        done [2];
  logic [7:0]  result [2];
  logic        carry [2];
  logic        mem_we [2];
  logic        mem_re [2];
  logic [11:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic [7:0]  mem_rdata [2];
  logic [7:0]  alu_a [2];
  logic [7:0]  alu_b [2];
  logic [3:0]  alu_op [2];
  logic [7:0]  alu_result [2];
  logic        alu_carry [2];

  logic [7:0]  mem [2][4096];
  logic [7:0]  rd1 [2];
  logic [7:0]  rd2 [2];
  logic        pl_en = 1'b0;
  int          pl_g = 0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  // model state: k = cycles since acceptance (0 = idle)
  int          k [2];
  int          tt [2];
  logic [11:0] ca [2];
  logic [11:0] cb [2];
  logic [11:0] cd [2];
  logic [3:0]  cop [2];
  logic        cwb [2];
  logic [7:0]  va [2];
  logic [7:0]  vb [2];
  logic [8:0]  ex [2];
  logic [7:0]  pa [2];
  logic [7:0]  pb [2];
  logic [7:0]  pr [2];
  logic        pc [2];
  logic [3:0]  pop [2];

  function automatic logic [8:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [3:0] op
  );
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    alu_mem_sequencer #(
      .ADDR_W(12), .DATA_W(8), .OP_W(4),
      .MEM_RD_LAT(g + 1)
    ) u_dut (
      .clk(clk), .reset(rst_n),
      .start(start[g]),
      .a_addr(a_addr[g]), .b_addr(b_addr[g]),
      .dst_addr(dst_addr[g]),
      .opcode(opcode[g]), .wb(wb[g]),
      .busy(busy[g]), .done(done[g]),
      .result(result[g]), .carry(carry[g]),
      .mem_we(mem_we[g]), .mem_re(mem_re[g]),
      .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_op(alu_op[g]),
      .alu_result(alu_result[g]),
      .alu_carry(alu_carry[g])
    );
    assign {alu_carry[g], alu_result[g]} =
      alu_f(alu_a[g], alu_b[g], alu_op[g]);
    assign mem_rdata[g] = (g == 0) ? rd1[g] : rd2[g];
  end

  initial forever #5 clk = ~clk;

  // memory: read sampled on the edge, one extra stage for latency 2
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pl_en && pl_g == g) mem[g][pl_addr] <= pl_data;
      if (mem_we[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
      if (mem_re[g]) rd1[g] <= mem[g][mem_addr[g]];
      rd2[g] <= rd1[g];
    end
  end

  // behavioural model: a command occupies 4+2L cycles (+1 with write-back)
  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        k[g]   <= 0;
        tt[g]  <= 0;
        pa[g]  <= '0;
        pb[g]  <= '0;
        pr[g]  <= '0;
        pc[g]  <= 1'b0;
        pop[g] <= '0;
      end else if (k[g] == 0) begin
        if (start[g]) begin
          ca[g]  <= a_addr[g];
          cb[g]  <= b_addr[g];
          cd[g]  <= dst_addr[g];
          cop[g] <= opcode[g];
          cwb[g] <= wb[g];
          va[g]  <= mem[g][a_addr[g]];
          vb[g]  <= mem[g][b_addr[g]];
          ex[g]  <= alu_f(mem[g][a_addr[g]],
                          mem[g][b_addr[g]], opcode[g]);
          tt[g]  <= (wb[g] ? 5 : 4) + 2 * (g + 1);
          k[g]   <= 1;
        end
      end else if (k[g] == tt[g]) begin
        k[g]   <= 0;
        pa[g]  <= va[g];
        pb[g]  <= vb[g];
        pr[g]  <= ex[g][7:0];
        pc[g]  <= ex[g][8];
        pop[g] <= cop[g];
      end else begin
        k[g] <= k[g] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h want %0h at %0t",
               nm, g, act, exp, $time);
    end
  endtask

  task automatic cyc_check(input int g);
    int   kk;
    int   lt;
    int   t;
    logic ere;
    logic ewe;
    kk  = k[g];
    lt  = g + 1;
    t   = tt[g];
    ere = (kk == 1) || (kk == 2 + lt);
    ewe = (kk != 0) && cwb[g] && (kk == t - 1);
    chk("busy", g, 32'(busy[g]), 32'(kk != 0));
    chk("done", g, 32'(done[g]), 32'(kk != 0 && kk == t));
    chk("mem_re", g, 32'(mem_re[g]), 32'(ere));
    chk("mem_we", g, 32'(mem_we[g]), 32'(ewe));
    if (ere)
      chk("rd_addr", g, 32'(mem_addr[g]),
          32'(kk == 1 ? ca[g] : cb[g]));
    if (ewe) begin
      chk("wr_addr", g, 32'(mem_addr[g]), 32'(cd[g]));
      chk("wr_data", g, 32'(mem_wdata[g]), 32'(ex[g][7:0]));
    end
    chk("alu_op", g, 32'(alu_op[g]),
        32'(kk >= 1 ? cop[g] : pop[g]));
    chk("alu_a", g, 32'(alu_a[g]),
        32'(kk >= 2 + lt ? va[g] : pa[g]));
    chk("alu_b", g, 32'(alu_b[g]),
        32'(kk >= 3 + 2 * lt ? vb[g] : pb[g]));
    chk("result", g, 32'(result[g]),
        32'(kk >= 4 + 2 * lt ? ex[g][7:0] : pr[g]));
    chk("carry", g, 32'(carry[g]),
        32'(kk >= 4 + 2 * lt ? ex[g][8] : pc[g]));
    if (kk != 0 && kk == t && cwb[g])
      chk("wb_mem", g, 32'(mem[g][cd[g]]), 32'(ex[g][7:0]));
  endtask

  task automatic chk_zero(input int g);
    chk("rst_busy", g, 32'(busy[g]), 0);
    chk("rst_done", g, 32'(done[g]), 0);
    chk("rst_we", g, 32'(mem_we[g]), 0);
    chk("rst_re", g, 32'(mem_re[g]), 0);
    chk("rst_result", g, 32'(result[g]), 0);
    chk("rst_carry", g, 32'(carry[g]), 0);
    chk("rst_alu_a", g, 32'(alu_a[g]), 0);
    chk("rst_alu_b", g, 32'(alu_b[g]), 0);
    chk("rst_alu_op", g, 32'(alu_op[g]), 0);
    chk("rst_addr", g, 32'(mem_addr[g]), 0);
    chk("rst_wdata", g, 32'(mem_wdata[g]), 0);
  endtask

  task automatic poke(input int g, input logic [11:0] ad,
                      input logic [7:0] d);
    pl_en   = 1'b1;
    pl_g    = g;
    pl_addr = ad;
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  task automatic set_cmd(input int g, input logic [11:0] a,
                         input logic [11:0] b,
                         input logic [11:0] d,
                         input logic [3:0] op, input logic w);
    a_addr[g]   = a;
    b_addr[g]   = b;
    dst_addr[g] = d;
    opcode[g]   = op;
    wb[g]       = w;
  endtask

  // called just after the accepting edge; returns edges until done
  task automatic wait_done(input int g, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done[g]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic cmd(input int g, input logic [11:0] a,
                     input logic [11:0] b,
                     input logic [11:0] d,
                     input logic [3:0] op, input logic w,
                     output int lat);
    set_cmd(g, a, b, d, op, w);
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    set_cmd(g, 12'($urandom), 12'($urandom), 12'($urandom),
            4'($urandom), 1'($urandom));
    wait_done(g, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int nd;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0;
      set_cmd(g, '0, '0, '0, '0, 1'b0);
    end
    fork
      forever begin
        @(negedge clk);
        if (rst_n)
          for (int g = 0; g < 2; g++) cyc_check(g);
      end
    join_none

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 1 + 2 with write-back
    poke(0, 12'h000, 8'h01);
    poke(0, 12'h800, 8'h02);
    cmd(0, 12'h000, 12'h800, 12'h001, 4'h0, 1'b1, lat);
    chk("t1_lat", 0, 32'(lat), 6);
    chk("t1_result", 0, 32'(result[0]), 32'h03);
    chk("t1_carry", 0, 32'(carry[0]), 0);
    chk("t1_mem", 0, 32'(mem[0][12'h001]), 32'h03);

    // carry out
    poke(0, 12'h020, 8'hFF);
    poke(0, 12'h021, 8'h01);
    poke(0, 12'h022, 8'h77);
    cmd(0, 12'h020, 12'h021, 12'h022, 4'h0, 1'b1, lat);
    chk("t2_result", 0, 32'(result[0]), 32'h00);
    chk("t2_carry", 0, 32'(carry[0]), 1);
    chk("t2_mem", 0, 32'(mem[0][12'h022]), 32'h00);

    // no write-back
    poke(0, 12'h030, 8'h5A);
    poke(0, 12'h031, 8'h03);
    poke(0, 12'h032, 8'h04);
    cmd(0, 12'h031, 12'h032, 12'h030, 4'h0, 1'b0, lat);
    chk("t3_lat", 0, 32'(lat), 5);
    chk("t3_result", 0, 32'(result[0]), 32'h07);
    chk("t3_mem", 0, 32'(mem[0][12'h030]), 32'h5A);

    // start during RD_B and DONE is ignored; next cycle accepted
    set_cmd(0, 12'h031, 12'h032, 12'h033, 4'h0, 1'b1);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    nd = 0;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      if (done[0]) nd++;
      if (n == 2) begin
        set_cmd(0, 12'h020, 12'h020, 12'h034, 4'h1, 1'b1);
        start[0] = 1'b1;
      end
      if (n == 3) start[0] = 1'b0;
      if (n == 6) begin
        set_cmd(0, 12'h020, 12'h021, 12'h024, 4'h0, 1'b1);
        start[0] = 1'b1;
      end
    end
    chk("t4_ndone", 0, 32'(nd), 1);
    chk("t4_idle", 0, 32'(busy[0]), 0);
    chk("t4_first", 0, 32'(result[0]), 32'h07);
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, lat);
    chk("t4_lat", 0, 32'(lat), 6);
    chk("t4_result", 0, 32'(result[0]), 32'h00);
    chk("t4_carry", 0, 32'(carry[0]), 1);
    @(posedge clk); #1;

    // reset in WAIT_B aborts the command
    poke(0, 12'h040, 8'h99);
    set_cmd(0, 12'h000, 12'h800, 12'h040, 4'h0, 1'b1);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_zero(0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_nowrite", 0, 32'(mem[0][12'h040]), 32'h99);
    poke(0, 12'h001, 8'h00);
    cmd(0, 12'h000, 12'h800, 12'h001, 4'h0, 1'b1, lat);
    chk("t5_lat", 0, 32'(lat), 6);
    chk("t5_result", 0, 32'(result[0]), 32'h03);
    chk("t5_mem", 0, 32'(mem[0][12'h001]), 32'h03);

    // latency 2, same address for both operands and destination
    poke(1, 12'h010, 8'h05);
    cmd(1, 12'h010, 12'h010, 12'h010, 4'h0, 1'b1, lat);
    chk("t6_lat", 1, 32'(lat), 8);
    chk("t6_result", 1, 32'(result[1]), 32'h0A);
    chk("t6_mem", 1, 32'(mem[1][12'h010]), 32'h0A);

    // random commands on both instances
    for (int a = 0; a < 32; a++) begin
      poke(0, 12'(a), 8'($urandom));
      poke(1, 12'(a), 8'($urandom));
    end
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (i == 700) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      for (int g = 0; g < 2; g++) begin
        start[g] = ($urandom_range(3) == 0);
        set_cmd(g, 12'($urandom_range(31)),
                12'($urandom_range(31)),
                12'($urandom_range(31)),
                4'($urandom_range(7)),
                1'($urandom_range(1)));
      end
    end
    for (int g = 0; g < 2; g++) start[g] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
